sha256_msg_sched: RTL and testbench
===================================

# sha256_msg_sched

Sequencer for the SHA-256 message schedule: it accepts one 512-bit block as 16 big-endian 32-bit words and emits the 64 schedule words W[0..63], one per cycle, under valid/ready backpressure. For t ≥ 16 it computes W[t] with `sha256_s0` and `sha256_s1` over a 16-word sliding window. It sits between the block-padding/input FIFO and the compression round engine, which consumes one W per round.

## Interface
Parameters: none (word width fixed at 32, block length fixed at 16 words, schedule length fixed at 64).

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- abort  in  1  synchronous flush; the block returns to LOAD on the next edge.
- in_valid  in  1  in_data holds a message word.
- in_ready  out  1  block can accept a word; equals (state==LOAD).
- in_data  in  32  message word M[i], loaded in order M[0] to M[15].
- w_valid  out  1  w_data holds a schedule word; equals (state==EMIT).
- w_ready  in  1  round engine accepts w_data.
- w_data  out  32  W[w_idx]; driven directly from register win[0].
- w_idx  out  6  index t of the word on w_data.
- w_last  out  1  w_valid && w_idx==63.
- busy  out  1  high when the state is not LOAD, or when the load count is nonzero.

## Operation
Storage:
- win[0..15] × 32 bits, a shift window.
- cnt, 6 bits: number of words loaded while in LOAD, current t while in EMIT.
- state ∈ {LOAD, EMIT}.

Sigma functions:
- sha256_s0(x) = ROTR7 ^ ROTR18 ^ SHR3.
- sha256_s1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Both are combinational instances.

LOAD state:
- On each in_valid && in_ready: win[k] ← win[k+1] for k = 0..14, win[15] ← in_data, cnt++.
- On the 16th accept (cnt==15): the next state is EMIT and cnt ← 0.
- After this, win[0..15] = M[0..15].

EMIT state:
- nxt = s1(win[14]) + win[9] + s0(win[1]) + win[0], all additions mod 2^32 (carries discarded).
- On each w_valid && w_ready: shift the window left by one, win[15] ← nxt, cnt++.
- On the accept at cnt==63: the next state is LOAD and cnt ← 0.
- nxt is still computed and shifted in for t ≥ 48; those words are never emitted, which is harmless.

Other rules:
- No handshake means no state change. w_data, w_idx and w_valid stay stable while w_ready is low.
- abort has priority over every handshake in the same cycle. On the next edge: state ← LOAD, cnt ← 0. Any word presented in that cycle is dropped. The win contents are don't-care.
- Reset values: state=LOAD, cnt=0, win=all zeros. Therefore in_ready=1, w_valid=0, w_data=0, w_idx=0, w_last=0, busy=0.
- Reset asserted mid-block discards the block immediately, asynchronously.

## Timing
- Load: 16 accepted words. A word is accepted in any cycle where in_valid=1, since in_ready is held at 1 throughout LOAD.
- Latency: w_valid rises in the cycle after the edge that accepts M[15]. w_data=W[0]=M[0] in that cycle.
- Throughput: with w_ready held high, W[0..63] appear on 64 consecutive cycles.
- Block period: at best 80 cycles per block (16 load + 64 emit). There is no overlap between loading the next block and emitting the current one.
- in_ready rises in the cycle after the accept of W[63].
- There is no combinational path from w_ready to in_ready or w_valid. Both valids are purely state-decoded.
- Critical path: s0/s1 XOR trees feeding a 4-input 32-bit adder into win[15]. Use a CSA tree if timing requires it.

## Test plan
- "abc" block: load M = 61626380, then 0 ×14, then 00000018 with w_ready=1. Expected:
  - W[0]=61626380, W[15]=00000018, W[16]=61626380, W[17]=000F0000, W[18]=7DA86405.
  - w_last asserts on W[63] only.
  - in_ready returns the following cycle.
- Backpressure: same block, w_ready toggled randomly (including multi-cycle lows). The sequence and w_idx must match the w_ready=1 run exactly. w_data must hold stable while w_valid && !w_ready.
- Input gaps: in_valid low on random cycles during LOAD. EMIT must begin only after the 16th word is accepted, and the output must equal the gap-free run.
- Abort in EMIT at t=30, asserted together with w_ready=1. Expected:
  - The next cycle has w_valid=0, in_ready=1 and busy=0.
  - The word at t=30 counts as not consumed.
  - A new block loaded afterwards produces the correct W[0..63].
- Abort in LOAD after 7 words, with in_valid high in the same cycle. That word is dropped, and the next 16 words form a fresh block.
- Async reset mid-EMIT, asserted between edges. Outputs must go to their reset values immediately. After release, back-to-back random blocks must match a software model for ≥100 blocks.

Source files
------------

// File: rtl/sha256_msg_sched_if.sv
// Handshake bundle between the block loader, the schedule sequencer and the
// compression round engine. The sequencer uses the slave view.
interface sha256_msg_sched_if;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [5:0]  w_idx;
    logic        w_last;
    logic        busy;

    modport master (
        output abort, in_valid, in_data, w_ready,
        input  in_ready, w_valid, w_data, w_idx, w_last, busy
    );

    modport slave (
        input  abort, in_valid, in_data, w_ready,
        output in_ready, w_valid, w_data, w_idx, w_last, busy
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule sequencer: loads 16 message words into a shift
// window, then emits W[0..63] one per accepted handshake, computing each new
// word from the sliding window with the small sigma functions.

// Small sigma 0: ROTR7 ^ ROTR18 ^ SHR3
module sha256_s0 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
endmodule

// Small sigma 1: ROTR17 ^ ROTR19 ^ SHR10
module sha256_s1 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
endmodule

module sha256_msg_sched (
    input  logic               clk,
    input  logic               rst,
    sha256_msg_sched_if.slave  bus
);
    typedef enum logic {LOAD, EMIT} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] win [16];

    logic [31:0] s0_out;
    logic [31:0] s1_out;
    logic [31:0] nxt;
    logic        load_fire;
    logic        emit_fire;
    logic        shift_en;
    logic [31:0] shift_in;

    sha256_s0 u_s0 (.x(win[1]),  .y(s0_out));
    sha256_s1 u_s1 (.x(win[14]), .y(s1_out));

    // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], with win[0] = W[t-16].
    // Still computed past t=47; the extra words fall off the end unseen.
    assign nxt = s1_out + win[9] + s0_out + win[0];

    assign load_fire = (state == LOAD) && bus.in_valid;
    assign emit_fire = (state == EMIT) && bus.w_ready;
    // abort wins over any handshake presented in the same cycle
    assign shift_en  = !bus.abort && (load_fire || emit_fire);
    assign shift_in  = (state == LOAD) ? bus.in_data : nxt;

    // One register per window slot; every slot shifts down by one on a fire.
    for (genvar gi = 0; gi < 16; gi++) begin : g_win
        if (gi == 15) begin : g_tail
            // Tail slot takes the incoming message word or the new schedule word
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    win[gi] <= '0;
                else if (shift_en)
                    win[gi] <= shift_in;
            end
        end else begin : g_body
            // Body slot takes its upper neighbour
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    win[gi] <= '0;
                else if (shift_en)
                    win[gi] <= win[gi + 1];
            end
        end
    end

    // Phase control: count 16 loads, then 64 emits, then back to loading
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
        end else if (bus.abort) begin
            state <= LOAD;
            cnt   <= '0;
        end else begin
            case (state)
                LOAD: if (bus.in_valid) begin
                    if (cnt == 6'd15) begin
                        state <= EMIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                EMIT: if (bus.w_ready) begin
                    if (cnt == 6'd63) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: begin
                    state <= LOAD;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Both valids are pure state decodes, so w_ready never reaches them combinationally
    assign bus.in_ready = (state == LOAD);
    assign bus.w_valid  = (state == EMIT);
    assign bus.w_data   = win[0];
    assign bus.w_idx    = cnt;
    assign bus.w_last   = (state == EMIT) && (cnt == 6'd63);
    assign bus.busy     = (state != LOAD) || (cnt != 6'd0);
endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed + random bench for sha256_msg_sched. Expected schedule words come
// from a recurrence model and are queued when a block finishes loading.
module tb_sha256_msg_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_msg_sched_if bus ();

    sha256_msg_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] blk [16];
    logic [31:0] ws  [64];
    logic [37:0] exp_q [$];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic compute_ws();
        for (int t = 0; t < 16; t++) ws[t] = blk[t];
        for (int t = 16; t < 64; t++)
            ws[t] = ms1(ws[t-2]) + ws[t-7] + ms0(ws[t-15]) + ws[t-16];
    endtask

    task automatic rand_block();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        compute_ws();
    endtask

    task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called and returns at a negedge. abort_after>=0 aborts while presenting that word.
    task automatic load_block(input int gap_pct, input int abort_after);
        for (int i = 0; i < 16; i++) begin
            int guard = 0;
            while ($urandom_range(99) < gap_pct && guard < 20) begin
                bus.in_valid = 1'b0;
                chk("no_early_emit", {37'b0, bus.w_valid}, 38'd0);
                guard++;
                @(negedge clk);
            end
            if (i == abort_after) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 32'hdeadbeef;
                bus.abort    = 1'b1;
                @(negedge clk);
                bus.abort    = 1'b0;
                bus.in_valid = 1'b0;
                chk("load_abort_in_ready", {37'b0, bus.in_ready}, 38'd1);
                chk("load_abort_busy",     {37'b0, bus.busy},     38'd0);
                chk("load_abort_w_valid",  {37'b0, bus.w_valid},  38'd0);
                return;
            end
            chk("in_ready", {37'b0, bus.in_ready}, 38'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = blk[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("latency_w_valid",  {37'b0, bus.w_valid},  38'd1);
        chk("latency_in_ready", {37'b0, bus.in_ready}, 38'd0);
        chk("latency_w0",       {6'b0, bus.w_data},    {6'b0, blk[0]});
        for (int t = 0; t < 64; t++) exp_q.push_back({6'(t), ws[t]});
    endtask

    // kill_mode 0: abort with w_ready=1 at t=kill_at; 1: async reset between edges.
    task automatic drain(input int rdy_pct, input int kill_at, input int kill_mode);
        logic [37:0] e;
        logic        stalled = 1'b0;
        logic        rdy;
        logic [31:0] hold_d = '0;
        logic [5:0]  hold_i = '0;
        int          budget = 0;
        while (exp_q.size() > 0) begin
            if (budget > 3000) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: remaining %0d words, required 0", exp_q.size());
                exp_q.delete();
                break;
            end
            budget++;
            chk("w_valid", {37'b0, bus.w_valid}, 38'd1);
            if (stalled) begin
                chk("hold_data", {6'b0, bus.w_data}, {6'b0, hold_d});
                chk("hold_idx",  {32'b0, bus.w_idx}, {32'b0, hold_i});
            end
            e = exp_q[0];
            if (kill_at >= 0 && int'(e[37:32]) == kill_at) begin
                if (kill_mode == 0) begin
                    bus.abort   = 1'b1;
                    bus.w_ready = 1'b1;
                    @(negedge clk);
                    bus.abort   = 1'b0;
                    bus.w_ready = 1'b0;
                    chk("emit_abort_w_valid",  {37'b0, bus.w_valid},  38'd0);
                    chk("emit_abort_in_ready", {37'b0, bus.in_ready}, 38'd1);
                    chk("emit_abort_busy",     {37'b0, bus.busy},     38'd0);
                end else begin
                    bus.w_ready = 1'b0;
                    #2 rst = 1'b1;
                    #1;
                    chk("arst_in_ready", {37'b0, bus.in_ready}, 38'd1);
                    chk("arst_w_valid",  {37'b0, bus.w_valid},  38'd0);
                    chk("arst_w_data",   {6'b0, bus.w_data},    38'd0);
                    chk("arst_w_idx",    {32'b0, bus.w_idx},    38'd0);
                    chk("arst_w_last",   {37'b0, bus.w_last},   38'd0);
                    chk("arst_busy",     {37'b0, bus.busy},     38'd0);
                    @(negedge clk);
                    rst = 1'b0;
                end
                exp_q.delete();
                break;
            end
            rdy = ($urandom_range(99) < rdy_pct);
            bus.w_ready = rdy;
            if (rdy) begin
                void'(exp_q.pop_front());
                chk("w_data", {6'b0, bus.w_data},    {6'b0, e[31:0]});
                chk("w_idx",  {32'b0, bus.w_idx},    {32'b0, e[37:32]});
                chk("w_last", {37'b0, bus.w_last},   {37'b0, (e[37:32] == 6'd63)});
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hold_d  = bus.w_data;
                hold_i  = bus.w_idx;
            end
            @(negedge clk);
        end
        bus.w_ready = 1'b0;
        chk("end_in_ready", {37'b0, bus.in_ready}, 38'd1);
        chk("end_w_valid",  {37'b0, bus.w_valid},  38'd0);
        chk("end_busy",     {37'b0, bus.busy},     38'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.w_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {37'b0, bus.in_ready}, 38'd1);
        chk("rst_w_valid",  {37'b0, bus.w_valid},  38'd0);
        chk("rst_w_data",   {6'b0, bus.w_data},    38'd0);
        chk("rst_w_idx",    {32'b0, bus.w_idx},    38'd0);
        chk("rst_w_last",   {37'b0, bus.w_last},   38'd0);
        chk("rst_busy",     {37'b0, bus.busy},     38'd0);

        // "abc" block with known schedule values pinned as literals
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        compute_ws();
        ws[16] = 32'h61626380;
        ws[17] = 32'h000f0000;
        ws[18] = 32'h7da86405;
        load_block(0, -1);
        $display("abc block loaded, draining with w_ready=1");
        drain(100, -1, 0);

        // Same block under random backpressure
        compute_ws();
        load_block(0, -1);
        $display("abc block loaded, draining with random w_ready");
        drain(50, -1, 0);

        // Same block with input gaps
        load_block(40, -1);
        $display("abc block loaded with input gaps");
        drain(100, -1, 0);

        // Abort in EMIT at t=30, then a fresh block
        load_block(0, -1);
        drain(100, 30, 0);
        $display("abort at t=30 applied");
        rand_block();
        load_block(0, -1);
        drain(100, -1, 0);
        $display("block after emit abort drained");

        // Abort in LOAD after 7 words, then a fresh block
        rand_block();
        load_block(0, 7);
        $display("abort after 7 loaded words applied");
        rand_block();
        load_block(0, -1);
        drain(100, -1, 0);
        $display("block after load abort drained");

        // Async reset mid-EMIT
        load_block(0, -1);
        drain(100, 20, 1);
        $display("async reset mid-emit applied");

        // Back-to-back random blocks
        for (int b = 0; b < 100; b++) begin
            rand_block();
            load_block(20, -1);
            drain(70, -1, 0);
            $display("random block %0d drained", b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
